// File: rtl/bist_sequencer.sv
// bist_sequencer: built-in self-test sequencer for a single full-adder CUT.
//
// A run walks the 3-bit pattern counter through all eight {a,b,cin} operand
// combinations, folds each CUT response into a 4-bit signature, then grades
// the signature against a golden value. Outside a run the functional
// operands pass straight through to the CUT.
//
// Build option:
//   BIST_MISR_EN defined   : signature is a 4-bit MISR, graded against GOLDEN_SIG.
//   BIST_MISR_EN undefined : signature counts per-pattern mismatches against an
//                            internal full-adder model, graded against GOLDEN_CNT.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       level; sampled high in idle launches a run
//   func_a, func_b, func_cin    functional-mode operands
//   cut_a, cut_b, cut_cin       operands driven to the CUT
//   cut_resp                    CUT response {sum, cout}
//   busy                        high while patterns are applied or graded
//   done                        one-cycle pulse when a run completes
//   pass                        grade of the last completed run (sticky)
//   signature                   MISR value or mismatch count (sticky)
module bist_sequencer #(
  parameter logic [3:0] GOLDEN_SIG = 4'h2,
  parameter logic [3:0] GOLDEN_CNT = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       func_a,
  input  logic       func_b,
  input  logic       func_cin,
  output logic       cut_a,
  output logic       cut_b,
  output logic       cut_cin,
  input  logic [1:0] cut_resp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] signature
);

  typedef enum logic [1:0] {StIdle, StRun, StComp, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] pat_q, pat_d;
  logic [3:0] sig_q, sig_d;
  logic       pass_q, pass_d;
  logic [3:0] sig_upd;
  logic [3:0] golden;

`ifdef BIST_MISR_EN
  logic unused_golden_cnt;
  assign unused_golden_cnt = ^GOLDEN_CNT;
  assign golden = GOLDEN_SIG;

  // Shift toward bit 3; bit 3 feeds back into bits 1 and 0.
  always_comb begin
    sig_upd = {sig_q[2], sig_q[1], sig_q[0] ^ sig_q[3] ^ cut_resp[1], sig_q[3] ^ cut_resp[0]};
  end
`else
  logic       unused_golden_sig;
  logic [1:0] exp_resp;
  logic       mismatch;
  assign unused_golden_sig = ^GOLDEN_SIG;
  assign golden = GOLDEN_CNT;

  // Reference full adder on the pattern register: {sum, majority carry}.
  always_comb begin
    exp_resp = {^pat_q, (pat_q[2] & pat_q[1]) | (pat_q[2] & pat_q[0]) | (pat_q[1] & pat_q[0])};
    mismatch = (cut_resp != exp_resp);
    sig_upd  = sig_q + {3'b000, mismatch};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= 3'd0;
      sig_q   <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pat_d   = 3'd0;
          sig_d   = 4'd0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        sig_d = sig_upd;
        // Pattern 7 is the last one; hold the counter rather than wrap.
        if (pat_q == 3'd7) begin
          state_d = StComp;
        end else begin
          pat_d = pat_q + 3'd1;
        end
      end
      StComp: begin
        pass_d  = (sig_q == golden);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy      = (state_q == StRun) || (state_q == StComp);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign signature = sig_q;

  // Test patterns own the CUT whenever busy, so functional operands never leak in.
  always_comb begin
    if (busy) begin
      {cut_a, cut_b, cut_cin} = pat_q;
    end else begin
      {cut_a, cut_b, cut_cin} = {func_a, func_b, func_cin};
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
module tb_bist_sequencer;

`ifdef BIST_MISR_EN
  localparam bit       MisrBuild    = 1'b1;
  localparam logic [3:0] CleanSig   = 4'h2;
  localparam logic [3:0] SumSa1Mid  = 4'hC;  // after patterns 0..3, sum stuck-at-1
`else
  localparam bit       MisrBuild    = 1'b0;
  localparam logic [3:0] CleanSig   = 4'd0;
  localparam logic [3:0] SumSa1Mid  = 4'd2;  // patterns 0 and 3 mismatch
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       func_a, func_b, func_cin;
  logic       cut_a, cut_b, cut_cin;
  logic [1:0] cut_resp;
  logic       busy, done, pass;
  logic [3:0] signature;

  int total;
  int bad;
  int fault;  // 0 none, 1 sum stuck-at-1, 2 input a stuck-at-0

  bist_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func_a    (func_a),
    .func_b    (func_b),
    .func_cin  (func_cin),
    .cut_a     (cut_a),
    .cut_b     (cut_b),
    .cut_cin   (cut_cin),
    .cut_resp  (cut_resp),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational full-adder CUT with optional injected fault.
  always_comb begin
    logic a_eff, s, c;
    a_eff = (fault == 2) ? 1'b0 : cut_a;
    s = a_eff ^ cut_b ^ cut_cin;
    c = (a_eff & cut_b) | (a_eff & cut_cin) | (cut_b & cut_cin);
    if (fault == 1) s = 1'b1;
    cut_resp = {s, c};
  end

  // Launch a run from idle; index i is the sample #1 after the i-th edge,
  // edge 0 being the one that samples start.
  task automatic do_run(input bit toggle, output int busy_cyc, output int done_idx,
                        output int done_cnt);
    @(negedge clk);
    start = 1'b1;
    busy_cyc = 0;
    done_idx = -1;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (toggle && i < 8) start = ~start;
      else start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, pass, signature} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b sig=%h, want all 0",
               busy, done, pass, signature);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_functional_mux();
    logic [2:0] exp_pat;
    func_a = 1'b1; func_b = 1'b1; func_cin = 1'b0;
    #1;
    total++;
    if ({cut_a, cut_b, cut_cin} !== 3'b110 || cut_resp !== 2'b01) begin
      bad++;
      $display("FAIL func_passthrough: got cut=%b%b%b resp=%b, want cut=110 resp=01",
               cut_a, cut_b, cut_cin, cut_resp);
    end
    func_a = 1'b1; func_b = 1'b1; func_cin = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_pat = (i < 8) ? 3'(i) : 3'd7;
      total++;
      if ({cut_a, cut_b, cut_cin} !== exp_pat) begin
        bad++;
        $display("FAIL run_cut_follows_pat[%0d]: got %b%b%b, want %b",
                 i, cut_a, cut_b, cut_cin, exp_pat);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cut_a, cut_b, cut_cin} !== 3'b111) begin
      bad++;
      $display("FAIL func_after_run: got %b%b%b, want 111", cut_a, cut_b, cut_cin);
    end
    func_a = 1'b0; func_b = 1'b0; func_cin = 1'b0;
  endtask

  task automatic test_clean_run();
    int bc, di, dc;
    fault = 0;
    do_run(1'b0, bc, di, dc);
    total++;
    if (bc !== 9) begin
      bad++;
      $display("FAIL clean_busy_cycles: got %0d, want 9", bc);
    end
    total++;
    if (di !== 9 || dc !== 1) begin
      bad++;
      $display("FAIL clean_done_pulse: got idx=%0d count=%0d, want idx=9 count=1", di, dc);
    end
    total++;
    if (pass !== 1'b1 || signature !== CleanSig) begin
      bad++;
      $display("FAIL clean_result: got pass=%b sig=%h, want pass=1 sig=%h",
               pass, signature, CleanSig);
    end
  endtask

  task automatic test_stuck_sum();
    int bc, di, dc;
    fault = 1;
    do_run(1'b0, bc, di, dc);
    fault = 0;
    total++;
    if (pass !== 1'b0 || dc !== 1) begin
      bad++;
      $display("FAIL sum_sa1_pass: got pass=%b done_count=%0d, want pass=0 done_count=1",
               pass, dc);
    end
    total++;
    if (MisrBuild ? (signature === 4'h2) : (signature !== 4'd4)) begin
      bad++;
      $display("FAIL sum_sa1_sig: got %h, want %s", signature,
               MisrBuild ? "not 2" : "4");
    end
  endtask

  task automatic test_stuck_a();
    int bc, di, dc;
    fault = 2;
    do_run(1'b0, bc, di, dc);
    fault = 0;
    total++;
    if (pass !== 1'b0) begin
      bad++;
      $display("FAIL a_sa0_pass: got %b, want 0", pass);
    end
    total++;
    if (MisrBuild ? (signature === 4'h2) : (signature !== 4'd4)) begin
      bad++;
      $display("FAIL a_sa0_sig: got %h, want %s", signature, MisrBuild ? "not 2" : "4");
    end
  endtask

  task automatic test_reset_midrun();
    int bc, di, dc;
    bit seen;
    fault = 1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    total++;
    if (signature !== SumSa1Mid || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_before_rst: got sig=%h busy=%b, want sig=%h busy=1",
               signature, busy, SumSa1Mid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, pass, signature} !== 7'd0) begin
      bad++;
      $display("FAIL midrun_async_rst: got busy=%b done=%b pass=%b sig=%h, want all 0",
               busy, done, pass, signature);
    end
    @(negedge clk);
    rst = 1'b0;
    fault = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midrun_no_resume: got activity=1, want 0");
    end
    do_run(1'b0, bc, di, dc);
    total++;
    if (pass !== 1'b1 || dc !== 1 || signature !== CleanSig) begin
      bad++;
      $display("FAIL after_rst_run: got pass=%b done_count=%0d sig=%h, want 1 1 %h",
               pass, dc, signature, CleanSig);
    end
  endtask

  task automatic test_start_toggle();
    int bc, di, dc;
    do_run(1'b1, bc, di, dc);
    total++;
    if (bc !== 9 || di !== 9 || dc !== 1) begin
      bad++;
      $display("FAIL toggle_run: got busy=%0d done_idx=%0d done_count=%0d, want 9 9 1",
               bc, di, dc);
    end
    total++;
    if (pass !== 1'b1) begin
      bad++;
      $display("FAIL toggle_pass: got %b, want 1", pass);
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1, dc;
    d0 = -1;
    d1 = -1;
    dc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 21) start = 1'b0;
      if (done) begin
        if (dc == 0) d0 = i;
        else if (dc == 1) d1 = i;
        dc++;
      end
      if (i == 10) begin
        total++;
        if (pass !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL b2b_idle_sticky: got pass=%b busy=%b, want 1 0", pass, busy);
        end
      end
      if (i == 11) begin
        total++;
        if (pass !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_relaunch: got pass=%b busy=%b, want 0 1", pass, busy);
        end
      end
    end
    total++;
    if (d0 !== 9 || d1 !== 20 || dc !== 2) begin
      bad++;
      $display("FAIL b2b_done: got first=%0d second=%0d count=%0d, want 9 20 2", d0, d1, dc);
    end
    total++;
    if (pass !== 1'b1 || signature !== CleanSig) begin
      bad++;
      $display("FAIL b2b_result: got pass=%b sig=%h, want 1 %h", pass, signature, CleanSig);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    fault = 0;
    rst = 1'b1;
    start = 1'b0;
    func_a = 1'b0;
    func_b = 1'b0;
    func_cin = 1'b0;
    test_reset();
    test_functional_mux();
    test_clean_run();
    test_stuck_sum();
    test_stuck_a();
    test_reset_midrun();
    test_start_toggle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
